// File: rtl/psum_ofifo_pkg.sv
// Shared sizing defaults and the partial-sum type for the MAC array output FIFO.
package psum_ofifo_pkg;
    localparam int COL         = 8;
    localparam int PSUM_BW     = 16;
    localparam int OFIFO_DEPTH = 64;

    typedef logic signed [PSUM_BW-1:0] psum_t;
endpackage

// File: rtl/psum_ofifo_lane.sv
// Single-column synchronous FIFO for one MAC array column (module ofifo_lane).
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module ofifo_lane
    import psum_ofifo_pkg::*;
#(
    parameter int bw    = PSUM_BW,
    parameter int depth = OFIFO_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic          rd,
    input  logic [bw-1:0] din,
    output logic [bw-1:0] dout,
    output logic          empty,
    output logic          full
);
    localparam int AW = $clog2(depth);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [bw-1:0] mem [depth];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          rd_ok;
    logic          wr_ok;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd_ok = rd && !empty;
    // a pop in the same edge frees the slot, so a write to a full lane still lands
    assign wr_ok = wr && (!full || rd_ok);
    assign dout  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + PTR_ONE;
            if (rd_ok) rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !reset) mem[wptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/psum_ofifo.sv
// Per-column psum FIFOs that re-align skewed array columns and pop whole rows.
// Optional PSUM_OFIFO_RELU_EN: clamp negative heads to zero as they load into out.
module psum_ofifo
    import psum_ofifo_pkg::*;
#(
    parameter int col     = COL,
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = OFIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   overflow
);
    logic [col-1:0]         empty;
    logic [col-1:0]         full;
    logic [col-1:0]         drop;
    logic [psum_bw*col-1:0] row_nxt;
    logic                   rd_acc;

    assign o_valid = ~|empty;
    assign o_full  = |full;
    assign o_ready = ~o_full;
    assign rd_acc  = rd & o_valid;

    genvar c;
    generate
        for (c = 0; c < col; c++) begin : g_lane
            logic [psum_bw-1:0] head;

            ofifo_lane #(
                .bw    (psum_bw),
                .depth (depth)
            ) u_lane (
                .clk   (clk),
                .reset (reset),
                .wr    (wr[c]),
                .rd    (rd_acc),
                .din   (in[psum_bw*c +: psum_bw]),
                .dout  (head),
                .empty (empty[c]),
                .full  (full[c])
            );

`ifdef PSUM_OFIFO_RELU_EN
            assign row_nxt[psum_bw*c +: psum_bw] = head[psum_bw-1] ? '0 : head;
`else
            assign row_nxt[psum_bw*c +: psum_bw] = head;
`endif
            assign drop[c] = wr[c] & full[c] & ~rd_acc;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            out      <= '0;
            overflow <= 1'b0;
        end else begin
            if (rd_acc) out <= row_nxt;
            if (|drop)  overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_psum_ofifo.sv
// Bench for psum_ofifo: queue-based row model checked every cycle plus literal row checks.
module tb_psum_ofifo;
    import psum_ofifo_pkg::*;

    localparam int W = PSUM_BW * COL;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  in = '0;
    logic [COL-1:0] wr = '0;
    logic          rd = 1'b0;
    logic [W-1:0]  out;
    logic          o_valid, o_full, o_ready, overflow;

    int n_chk = 0;
    int n_fail = 0;

    psum_ofifo dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in),
        .wr       (wr),
        .rd       (rd),
        .out      (out),
        .o_valid  (o_valid),
        .o_full   (o_full),
        .o_ready  (o_ready),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [PSUM_BW-1:0] q [COL][$];
    logic [W-1:0]       m_out = '0;
    logic               m_ovf = 1'b0;
    bit                 armed = 1'b0;

    function automatic logic [PSUM_BW-1:0] shape(input logic [PSUM_BW-1:0] v);
`ifdef PSUM_OFIFO_RELU_EN
        psum_t s;
        s = psum_t'(v);
        return (s < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    function automatic bit m_valid();
        for (int c = 0; c < COL; c++) if (q[c].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_full();
        for (int c = 0; c < COL; c++) if (q[c].size() == OFIFO_DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        bit racc;
        if (reset) begin
            for (int c = 0; c < COL; c++) q[c].delete();
            m_out = '0;
            m_ovf = 1'b0;
            armed = 1'b1;
        end else begin
            racc = rd && m_valid();
            if (racc)
                for (int c = 0; c < COL; c++) m_out[c*PSUM_BW +: PSUM_BW] = shape(q[c].pop_front());
            for (int c = 0; c < COL; c++)
                if (wr[c]) begin
                    if (q[c].size() < OFIFO_DEPTH) q[c].push_back(in[c*PSUM_BW +: PSUM_BW]);
                    else m_ovf = 1'b1;
                end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("cyc_out", out, m_out);
            chk("cyc_o_valid", W'(o_valid), W'(m_valid()));
            chk("cyc_o_full", W'(o_full), W'(m_full()));
            chk("cyc_o_ready", W'(o_ready), W'(!m_full()));
            chk("cyc_overflow", W'(overflow), W'(m_ovf));
        end
    end

    // ---------------- stimulus ----------------
    // Inputs change just after a falling edge; returns just after the next one.
    task automatic step(input logic [COL-1:0] w, input logic r, input logic [W-1:0] d, input logic rs);
        wr = w;
        rd = r;
        in = d;
        reset = rs;
        @(negedge clk);
        #1;
        wr = '0;
        rd = 1'b0;
        reset = 1'b0;
    endtask

    function automatic logic [W-1:0] row_of(input logic [15:0] base, input int r);
        logic [W-1:0] v;
        for (int c = 0; c < COL; c++) v[c*PSUM_BW +: PSUM_BW] = base + 16'(r*8 + c);
        return v;
    endfunction

    logic [W-1:0] relu_in;
    logic [W-1:0] relu_exp;

    initial begin
        @(negedge clk);
        #1;
        step('0, 0, '0, 1);
        step('0, 0, '0, 1);
        chk("rst_out", out, '0);
        chk("rst_o_valid", W'(o_valid), W'(0));
        chk("rst_o_full", W'(o_full), W'(0));
        chk("rst_o_ready", W'(o_ready), W'(1));
        chk("rst_overflow", W'(overflow), W'(0));

        // skewed fill, one column per cycle
        for (int c = 0; c < COL; c++) begin
            logic [W-1:0] d;
            d = '0;
            d[c*PSUM_BW +: PSUM_BW] = 16'h0100 + 16'(c);
            step(COL'(1) << c, 0, d, 0);
            if (c == COL-2) chk("skew_valid_before_c7", W'(o_valid), W'(0));
        end
        chk("skew_valid_after_c7", W'(o_valid), W'(1));
        step('0, 1, '0, 0);
        chk("skew_row", out, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
        chk("skew_valid_fall", W'(o_valid), W'(0));

        // full boundary and overflow
        for (int r = 0; r < OFIFO_DEPTH; r++) begin
            step('1, 0, row_of(16'h1000, r), 0);
            if (r == OFIFO_DEPTH-2) chk("full_at_63", W'(o_full), W'(0));
        end
        chk("full_at_64", W'(o_full), W'(1));
        chk("ready_at_64", W'(o_ready), W'(0));
        step('1, 0, {COL{16'hDEAD}}, 0);
        chk("ovf_set", W'(overflow), W'(1));
        for (int r = 0; r < OFIFO_DEPTH; r++) begin
            step('0, 1, '0, 0);
            if (r == 0) chk("drain_first", out, 128'h1007_1006_1005_1004_1003_1002_1001_1000);
            if (out[15:0] == 16'hDEAD) chk("drain_no_dead", out, '0);
        end
        chk("drain_last", out, 128'h11FF_11FE_11FD_11FC_11FB_11FA_11F9_11F8);
        chk("drain_empty", W'(o_valid), W'(0));

        // simultaneous read and write while full
        step('0, 0, '0, 1);
        for (int r = 0; r < OFIFO_DEPTH; r++) step('1, 0, row_of(16'h2000, r), 0);
        step('1, 1, row_of(16'h3000, 0), 0);
        chk("rw_full_out", out, 128'h2007_2006_2005_2004_2003_2002_2001_2000);
        chk("rw_full_ovf", W'(overflow), W'(0));
        chk("rw_full_full", W'(o_full), W'(1));
        for (int r = 0; r < OFIFO_DEPTH; r++) step('0, 1, '0, 0);
        chk("rw_wrap_last", out, 128'h3007_3006_3005_3004_3003_3002_3001_3000);
        chk("rw_wrap_empty", W'(o_valid), W'(0));

        // single column only: reads must be ignored
        for (int k = 0; k < 5; k++) begin
            logic [W-1:0] d;
            d = '0;
            d[3*PSUM_BW +: PSUM_BW] = 16'h4000 + 16'(k);
            step(8'h08, 1, d, 0);
        end
        chk("part_valid", W'(o_valid), W'(0));
        chk("part_out_hold", out, 128'h3007_3006_3005_3004_3003_3002_3001_3000);
        step(8'hF7, 0, 128'h5007_5006_5005_5004_0000_5002_5001_5000, 0);
        chk("part_valid_up", W'(o_valid), W'(1));
        step('0, 1, '0, 0);
        chk("part_row", out, 128'h5007_5006_5005_5004_4000_5002_5001_5000);
        chk("part_one_row", W'(o_valid), W'(0));
        step('0, 1, '0, 0);
        chk("part_row_hold", out, 128'h5007_5006_5005_5004_4000_5002_5001_5000);

        // reset in the middle of traffic
        step('0, 0, '0, 1);
        for (int r = 0; r < 10; r++) step('1, 0, row_of(16'h6000, r), 0);
        for (int k = 0; k < 55; k++) step(8'h01, 0, {COL{16'h7000 + 16'(k)}}, 0);
        chk("mid_ovf", W'(overflow), W'(1));
        chk("mid_full", W'(o_full), W'(1));
        step('1, 1, row_of(16'h6100, 0), 1);
        chk("mid_rst_valid", W'(o_valid), W'(0));
        chk("mid_rst_full", W'(o_full), W'(0));
        chk("mid_rst_ovf", W'(overflow), W'(0));
        chk("mid_rst_out", out, '0);
        step('0, 0, '0, 0);
        chk("mid_rst_not_stored", W'(o_valid), W'(0));

        // ReLU on negative heads (raw when the feature is off)
        relu_in = 128'h8001_7FFF_FFFF_0000_1234_FFFE_0002_8000;
`ifdef PSUM_OFIFO_RELU_EN
        relu_exp = 128'h0000_7FFF_0000_0000_1234_0000_0002_0000;
`else
        relu_exp = 128'h8001_7FFF_FFFF_0000_1234_FFFE_0002_8000;
`endif
        step('1, 0, relu_in, 0);
        step('0, 1, '0, 0);
        chk("relu_row", out, relu_exp);
        step('1, 1, row_of(16'h0010, 0), 0);
        step('0, 1, '0, 0);
        chk("relu_stored_raw_next", out, 128'h0017_0016_0015_0014_0013_0012_0011_0010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
